// File: rtl/adder_sum_stage.sv
// Sum stage of the pipelined prefix adder: queues {p, cin} per operand until the
// prefix tree returns its carry vector, then emits a registered sum/carry-out.
module adder_sum_stage #(
    parameter int N     = 32,
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [N-1:0]  p,
    input  logic          cin,
    input  logic          c_valid,
    input  logic [N-1:0]  c,
    output logic [N-1:0]  sum,
    output logic          cout,
    output logic          out_valid,
    output logic [LW-1:0] level,
    output logic          err_overflow,
    output logic          err_underflow
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [N-1:0] p;
        logic         cin;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [N-1:0]  r_sum;
    logic          r_cout;
    logic          r_out_valid;
    logic          r_err_overflow;
    logic          r_err_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    entry_t        w_head;
    logic [N-1:0]  w_sum;

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = c_valid && !w_empty;
    // A full queue still accepts a push when the same-cycle pop frees the head slot.
    assign w_push  = in_valid && (!w_full || c_valid);
    assign w_head  = r_mem[r_rd_ptr];
    // Bit i sums with the carry out of bit i-1; bit 0 uses the queued carry-in.
    assign w_sum   = w_head.p ^ {c[N-2:0], w_head.cin};

    // Queue storage carries no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {p, cin};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_level         <= '0;
            r_sum           <= '0;
            r_cout          <= 1'b0;
            r_out_valid     <= 1'b0;
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

            if (w_push && !w_pop)
                r_level <= r_level + LW'(1);
            else if (w_pop && !w_push)
                r_level <= r_level - LW'(1);

            r_out_valid <= w_pop;
            if (w_pop) begin
                r_sum  <= w_sum;
                r_cout <= c[N-1];
            end

            if (in_valid && w_full && !c_valid) r_err_overflow  <= 1'b1;
            if (c_valid && w_empty)             r_err_underflow <= 1'b1;
        end
    end

    assign sum           = r_sum;
    assign cout          = r_cout;
    assign out_valid     = r_out_valid;
    assign level         = r_level;
    assign err_overflow  = r_err_overflow;
    assign err_underflow = r_err_underflow;
endmodule

// File: tb/tb_adder_sum_stage.sv
// Bench for adder_sum_stage at N=8, DEPTH=4; a behavioural 3-cycle carry pipeline
// stands in for prefix_tree and expected results flow through a scoreboard queue.
module tb_adder_sum_stage;
    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int LAT   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [N-1:0]  p = '0;
    logic          cin = 1'b0;
    logic          c_valid = 1'b0;
    logic [N-1:0]  c = '0;
    logic [N-1:0]  sum;
    logic          cout;
    logic          out_valid;
    logic [LW-1:0] level;
    logic          err_overflow;
    logic          err_underflow;

    int checks = 0;
    int failures = 0;
    logic [N:0] sb[$];

    adder_sum_stage #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .p(p), .cin(cin),
        .c_valid(c_valid), .c(c), .sum(sum), .cout(cout), .out_valid(out_valid),
        .level(level), .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] carries(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic ci);
        logic cy;
        logic [N-1:0] r;
        cy = ci;
        for (int i = 0; i < N; i++) begin
            r[i] = (a[i] & b[i]) | ((a[i] ^ b[i]) & cy);
            cy   = r[i];
        end
        return r;
    endfunction

    task automatic step(input logic iv, input logic [N-1:0] pp, input logic ci,
                        input logic cv, input logic [N-1:0] cc);
        in_valid = iv; p = pp; cin = ci; c_valid = cv; c = cc;
        @(posedge clk); #1;
        in_valid = 1'b0; c_valid = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        step(0, '0, 0, 0, '0);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        logic [N:0] e;
        do_rst();
        e = {cout, sum};
        checks++;
        if (e !== '0 || out_valid !== 1'b0 || level !== '0 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got cout_sum=%h ov=%b lvl=%0d eo=%b eu=%b, need all zero",
                     e, out_valid, level, err_overflow, err_underflow);
        end
    endtask

    task automatic test_single();
        logic [N:0] e;
        do_rst();
        sb.push_back(9'h010);
        step(1, 8'h0E, 0, 0, '0);
        checks++;
        if (level !== LW'(1)) begin failures++; $display("FAIL single_level_push: got %0d need 1", level); end
        step(0, '0, 0, 0, '0);
        step(0, '0, 0, 0, '0);
        step(0, '0, 0, 1, 8'h0F);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid: got %b need 1", out_valid); end
        else begin
            e = sb.pop_front();
            checks++;
            if ({cout, sum} !== e) begin failures++; $display("FAIL single_sum: got %h need %h", {cout, sum}, e); end
        end
        checks++;
        if (level !== '0) begin failures++; $display("FAIL single_level_pop: got %0d need 0", level); end
        step(0, '0, 0, 0, '0);
        checks++;
        if (out_valid !== 1'b0 || sum !== 8'h10) begin
            failures++;
            $display("FAIL single_pulse_hold: got ov=%b sum=%h need ov=0 sum=10", out_valid, sum);
        end
    endtask

    task automatic test_carry_chain();
        logic [N:0] e;
        do_rst();
        sb.push_back(9'h100);
        step(1, 8'hFE, 0, 0, '0);
        sb.push_back(9'h100);
        step(1, 8'hFF, 1, 0, '0);
        for (int k = 0; k < 2; k++) begin
            step(0, '0, 0, 1, 8'hFF);
            checks++;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL carry_valid%0d: got %b need 1", k, out_valid); end
            else begin
                e = sb.pop_front();
                checks++;
                if ({cout, sum} !== e) begin failures++; $display("FAIL carry_sum%0d: got %h need %h", k, {cout, sum}, e); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a, b, pp;
        logic         ci;
        logic         dv[LAT];
        logic [N-1:0] dc[LAT];
        logic         cv;
        logic [N-1:0] cc;
        logic [N:0]   e;
        int outs = 0, run = 0, best = 0;
        do_rst();
        for (int i = 0; i < LAT; i++) begin dv[i] = 1'b0; dc[i] = '0; end
        for (int i = 0; i < 100 + LAT + 2; i++) begin
            cv = dv[LAT-1]; cc = dc[LAT-1];
            for (int s = LAT - 1; s > 0; s--) begin dv[s] = dv[s-1]; dc[s] = dc[s-1]; end
            if (i < 100) begin
                a = N'($urandom); b = N'($urandom); ci = 1'($urandom);
                pp = a ^ b;
                dv[0] = 1'b1; dc[0] = carries(a, b, ci);
                sb.push_back({1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci});
                step(1, pp, ci, cv, cc);
            end else begin
                dv[0] = 1'b0; dc[0] = '0;
                step(0, '0, 0, cv, cc);
            end
            if (out_valid) begin
                outs++; run++;
                if (run > best) best = run;
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL stream_extra_out: sum=%h with empty scoreboard", sum); end
                else begin
                    e = sb.pop_front();
                    if ({cout, sum} !== e) begin failures++; $display("FAIL stream_sum%0d: got %h need %h", outs, {cout, sum}, e); end
                end
            end else run = 0;
        end
        checks++;
        if (outs != 100 || best != 100 || sb.size() != 0) begin
            failures++;
            $display("FAIL stream_count: got outs=%0d run=%0d left=%0d need 100/100/0", outs, best, sb.size());
        end
        checks++;
        if (err_overflow !== 1'b0 || err_underflow !== 1'b0 || level !== '0) begin
            failures++;
            $display("FAIL stream_flags: got eo=%b eu=%b lvl=%0d need 0/0/0", err_overflow, err_underflow, level);
        end
    endtask

    task automatic test_overflow();
        logic [N:0] e;
        do_rst();
        for (int i = 1; i <= DEPTH; i++) begin
            sb.push_back(9'(i));
            step(1, N'(i), 0, 0, '0);
        end
        checks++;
        if (level !== LW'(DEPTH) || err_overflow !== 1'b0) begin
            failures++; $display("FAIL ovf_fill: got lvl=%0d eo=%b need 4/0", level, err_overflow);
        end
        step(1, 8'h55, 0, 0, '0);
        checks++;
        if (level !== LW'(DEPTH) || err_overflow !== 1'b1) begin
            failures++; $display("FAIL ovf_drop: got lvl=%0d eo=%b need 4/1", level, err_overflow);
        end
        sb.push_back(9'h066);
        step(1, 8'h66, 0, 1, '0);
        checks++;
        if (level !== LW'(DEPTH) || out_valid !== 1'b1 || err_underflow !== 1'b0) begin
            failures++; $display("FAIL ovf_pushpop: got lvl=%0d ov=%b eu=%b need 4/1/0", level, out_valid, err_underflow);
        end
        for (int k = 0; k <= DEPTH; k++) begin
            if (out_valid) begin
                e = sb.pop_front();
                checks++;
                if ({cout, sum} !== e) begin failures++; $display("FAIL ovf_drain%0d: got %h need %h", k, {cout, sum}, e); end
            end
            if (k < DEPTH) step(0, '0, 0, 1, '0);
        end
        checks++;
        if (level !== '0 || sb.size() != 0) begin
            failures++; $display("FAIL ovf_empty: got lvl=%0d left=%0d need 0/0", level, sb.size());
        end
    endtask

    task automatic test_underflow();
        logic [N:0] e;
        do_rst();
        step(0, '0, 0, 1, 8'hFF);
        checks++;
        if (err_underflow !== 1'b1 || out_valid !== 1'b0 || level !== '0) begin
            failures++; $display("FAIL udf_alone: got eu=%b ov=%b lvl=%0d need 1/0/0", err_underflow, out_valid, level);
        end
        do_rst();
        sb.push_back(9'h004);
        step(1, 8'h03, 1, 1, '0);
        checks++;
        if (err_underflow !== 1'b1 || out_valid !== 1'b0 || level !== LW'(1)) begin
            failures++; $display("FAIL udf_with_push: got eu=%b ov=%b lvl=%0d need 1/0/1", err_underflow, out_valid, level);
        end
        step(0, '0, 0, 1, carries(8'h03, 8'h00, 1'b1));
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {cout, sum} !== e) begin
            failures++; $display("FAIL udf_landed: got ov=%b sum=%h need 1/%h", out_valid, {cout, sum}, e);
        end
    endtask

    task automatic test_reset_mid();
        do_rst();
        step(0, '0, 0, 1, '0);
        for (int i = 0; i < 3; i++) step(1, N'(i), 0, 0, '0);
        rst = 1'b1;
        step(0, '0, 0, 0, '0);
        checks++;
        if (level !== '0 || out_valid !== 1'b0 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            failures++; $display("FAIL rst_mid: got lvl=%0d ov=%b eo=%b eu=%b need all 0",
                                 level, out_valid, err_overflow, err_underflow);
        end
        rst = 1'b0;
        sb.delete();
        step(0, '0, 0, 1, 8'hAA);
        checks++;
        if (err_underflow !== 1'b1 || out_valid !== 1'b0 || level !== '0) begin
            failures++; $display("FAIL rst_stale_pop: got eu=%b ov=%b lvl=%0d need 1/0/0", err_underflow, out_valid, level);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry_chain();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
